// File: rtl/hack_pkg.sv
// Shared definitions for the Hack data-memory arbiter.
// Holds the read-return owner encoding and the default bus widths.
package hack_pkg;

    localparam int HACK_ADDR_W = 15;
    localparam int HACK_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles the secondary master was denied.
// sat marks the cycle in which that master must win the next arbitration.
module arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] cnt,
    output logic       sat
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 4'd0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (inc && cnt != MAX_CNT) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign sat = (cnt == MAX_CNT);

endmodule

// File: rtl/hack_mem_arbiter.sv
// Shares the single-port data RAM between the Hack CPU and one DMA master.
// CPU has fixed priority, except that a starved DMA request wins one grant.
module hack_mem_arbiter
    import hack_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int ADDR_W   = HACK_ADDR_W,
    parameter int DATA_W   = HACK_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_din,
    output logic              dma_ready,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_dout,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [3:0]        wait_cnt;
    logic              sat;
    logic              grant_cpu;
    logic              grant_dma;
    owner_t            owner;
    owner_t            owner_next;
    logic [DATA_W-1:0] cpu_rd_hold;
    logic [DATA_W-1:0] dma_rd_hold;
    logic              ret_cpu;
    logic              ret_dma;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (!reset) begin
            if (dma_req && sat) begin
                grant_dma = 1'b1;
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (dma_req) begin
                grant_dma = 1'b1;
            end
        end
    end

    assign cpu_stall = !reset && cpu_req && !grant_cpu;
    assign dma_ready = grant_dma;

    // Idle cycles park the RAM address on the CPU port.
    always_comb begin
        ram_wr   = 1'b0;
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        if (grant_dma) begin
            ram_wr   = dma_wr;
            ram_addr = dma_addr;
            ram_din  = dma_din;
        end else if (grant_cpu) begin
            ram_wr = cpu_wr;
        end
    end

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!reset && dma_req && !grant_dma),
        .clr   (grant_dma),
        .cnt   (wait_cnt),
        .sat   (sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_next;
        end
    end

    always_comb begin
        owner_next = OWN_NONE;
        if (grant_cpu && !cpu_wr) begin
            owner_next = OWN_CPU;
        end else if (grant_dma && !dma_wr) begin
            owner_next = OWN_DMA;
        end
    end

    // A return already in flight when reset rises is dropped, not delivered.
    assign ret_cpu = (owner == OWN_CPU) && !reset;
    assign ret_dma = (owner == OWN_DMA) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rd_hold <= '0;
            dma_rd_hold <= '0;
        end else begin
            if (ret_cpu) begin
                cpu_rd_hold <= ram_dout;
            end
            if (ret_dma) begin
                dma_rd_hold <= ram_dout;
            end
        end
    end

    assign cpu_dout   = ret_cpu ? ram_dout : cpu_rd_hold;
    assign dma_rvalid = ret_dma;
    assign dma_dout   = ret_dma ? ram_dout : dma_rd_hold;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed bench for hack_mem_arbiter with a behavioural RAM and a
// scoreboard of expected read returns checked by an independent monitor.
module tb_hack_mem_arbiter;
    import hack_pkg::*;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cpu_req = 1'b0;
    logic              cpu_wr = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_din = '0;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_stall;
    logic              dma_req = 1'b0;
    logic              dma_wr = 1'b0;
    logic [ADDR_W-1:0] dma_addr = '0;
    logic [DATA_W-1:0] dma_din = '0;
    logic              dma_ready;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_dout;
    logic              ram_wr;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout = '0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_pass   = 0;
    logic [DATA_W-1:0] exp_cpu [$];
    logic [DATA_W-1:0] exp_dma [$];
    bit stim_done = 1'b0;

    hack_mem_arbiter #(
        .MAX_WAIT (4),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_stall  (cpu_stall),
        .dma_req    (dma_req),
        .dma_wr     (dma_wr),
        .dma_addr   (dma_addr),
        .dma_din    (dma_din),
        .dma_ready  (dma_ready),
        .dma_rvalid (dma_rvalid),
        .dma_dout   (dma_dout),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    always #5 clk = ~clk;

    // Single-port RAM with one cycle of registered read latency.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive just after the rising edge, return at the falling edge.
    task automatic step(input logic rst,
                        input logic c_req, input logic c_wr,
                        input logic [ADDR_W-1:0] c_addr, input logic [DATA_W-1:0] c_din,
                        input logic d_req, input logic d_wr,
                        input logic [ADDR_W-1:0] d_addr, input logic [DATA_W-1:0] d_din);
        @(posedge clk);
        #1;
        reset    = rst;
        cpu_req  = c_req;
        cpu_wr   = c_wr;
        cpu_addr = c_addr;
        cpu_din  = c_din;
        dma_req  = d_req;
        dma_wr   = d_wr;
        dma_addr = d_addr;
        dma_din  = d_din;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: compares every presented read return against the scoreboard.
    initial begin
        logic cpu_rd_pend;
        cpu_rd_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu_rd_pend && !reset) begin
                if (exp_cpu.size() == 0) check("cpu_return_unexpected", 32'd1, 32'd0);
                else check("cpu_dout", 32'(cpu_dout), 32'(exp_cpu.pop_front()));
            end
            if (dma_rvalid) begin
                if (exp_dma.size() == 0) check("dma_rvalid_unexpected", 32'(dma_rvalid), 32'd0);
                else check("dma_dout", 32'(dma_dout), 32'(exp_dma.pop_front()));
            end
            cpu_rd_pend = !reset && cpu_req && !cpu_wr && !cpu_stall;
        end
    end

    initial begin
        mem[16384] = 16'hBEEF;

        // Reset held with both masters requesting writes.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 15'd1, 16'd1, 1'b1, 1'b1, 15'd2, 16'd2);
            check("rst_dma_ready", 32'(dma_ready), 32'd0);
            check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
            check("rst_ram_wr", 32'(ram_wr), 32'd0);
            check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        end
        check("rst_cpu_dout", 32'(cpu_dout), 32'd0);
        check("rst_dma_dout", 32'(dma_dout), 32'd0);
        idle();

        // CPU alone: write then read back.
        step(1'b0, 1'b1, 1'b1, 15'd256, 16'd1110, 1'b0, 1'b0, '0, '0);
        check("cpu_wr_stall", 32'(cpu_stall), 32'd0);
        check("cpu_wr_ram_wr", 32'(ram_wr), 32'd1);
        check("cpu_wr_ram_addr", 32'(ram_addr), 32'd256);
        step(1'b0, 1'b1, 1'b0, 15'd256, 16'd0, 1'b0, 1'b0, '0, '0);
        exp_cpu.push_back(16'd1110);
        check("cpu_rd_stall", 32'(cpu_stall), 32'd0);
        idle();

        // DMA alone: read of a preloaded word.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 15'd16384, '0);
        exp_dma.push_back(16'hBEEF);
        check("dma_only_ready", 32'(dma_ready), 32'd1);
        check("dma_only_ram_addr", 32'(ram_addr), 32'd16384);
        idle();
        check("dma_dout_held", 32'(dma_dout), 32'hBEEF);

        // Ordering: CPU write wins, pending DMA read of the same word follows.
        step(1'b0, 1'b1, 1'b1, 15'd7, 16'd42, 1'b1, 1'b0, 15'd7, '0);
        check("ord_cpu_stall", 32'(cpu_stall), 32'd0);
        check("ord_dma_ready0", 32'(dma_ready), 32'd0);
        check("ord_ram_wr", 32'(ram_wr), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 15'd7, '0);
        exp_dma.push_back(16'd42);
        check("ord_dma_ready1", 32'(dma_ready), 32'd1);
        check("ord_ram_addr", 32'(ram_addr), 32'd7);
        idle();

        // Starvation: both masters write continuously; DMA wins every 5th cycle.
        for (int c = 1; c <= 15; c++) begin
            logic exp_g;
            exp_g = (c % 5 == 0);
            step(1'b0, 1'b1, 1'b1, 15'd100, 16'(c), 1'b1, 1'b1, 15'd200, 16'(c));
            check($sformatf("starve_dma_ready_c%0d", c), 32'(dma_ready), 32'(exp_g));
            check($sformatf("starve_cpu_stall_c%0d", c), 32'(cpu_stall), 32'(exp_g));
            check($sformatf("starve_ram_addr_c%0d", c), 32'(ram_addr), exp_g ? 32'd200 : 32'd100);
            check($sformatf("starve_wait_bound_c%0d", c), 32'(dut.wait_cnt <= 4'd4), 32'd1);
        end
        idle();

        // Reset arriving while a DMA read return is in flight.
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 15'd16384, '0);
        check("rmr_dma_ready", 32'(dma_ready), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
            check("rmr_rvalid_in_reset", 32'(dma_rvalid), 32'd0);
        end
        idle();
        check("rmr_rvalid_after_reset", 32'(dma_rvalid), 32'd0);
        check("rmr_owner_none", 32'(dut.owner), 32'(OWN_NONE));
        step(1'b0, 1'b1, 1'b0, 15'd256, 16'd0, 1'b0, 1'b0, '0, '0);
        exp_cpu.push_back(16'd1110);
        check("rmr_cpu_stall", 32'(cpu_stall), 32'd0);
        idle();
        idle();

        check("cpu_scoreboard_drained", 32'(exp_cpu.size()), 32'd0);
        check("dma_scoreboard_drained", 32'(exp_dma.size()), 32'd0);
        stim_done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Upper bound on run time in case the stimulus ever stalls.
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: stimulus incomplete, %0d/%0d checks passed", n_pass, n_checks);
            $fatal(1, "timeout");
        end
    end

endmodule
